// File: rtl/maxpool2d_stream.sv
// Streaming 2x2 / stride-2 max-pool over a raster-order feature map.
// A half-width line buffer carries the even-row pair maxima into the odd row.
module maxpool2d_stream #(
    parameter int WIDTH  = 32,
    parameter int HEIGHT = 32,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              frame_done
);

    localparam int CW  = $clog2(WIDTH);
    localparam int RW  = $clog2(HEIGHT);
    localparam int LBN = WIDTH / 2;
    localparam int IW  = (LBN > 1) ? $clog2(LBN) : 1;

    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [DATA_W-1:0] hreg;
    logic [DATA_W-1:0] lb [LBN];
    logic              last_pending;

    logic              in_accept;
    logic              out_accept;
    logic              load;
    logic              col_last;
    logic              row_last;
    logic [IW-1:0]     lb_idx;
    logic [DATA_W-1:0] lb_rd;
    logic [DATA_W-1:0] pair_max;
    logic [DATA_W-1:0] pool_max;

    assign in_ready   = !out_valid || out_ready;
    assign in_accept  = in_valid && in_ready;
    assign out_accept = out_valid && out_ready;
    assign frame_done = out_accept && last_pending;

    assign col_last = (col == CW'(WIDTH - 1));
    assign row_last = (row == RW'(HEIGHT - 1));
    assign lb_idx   = IW'(col >> 1);
    assign lb_rd    = lb[lb_idx];
    assign pair_max = (in_data > hreg) ? in_data : hreg;
    assign pool_max = (lb_rd > pair_max) ? lb_rd : pair_max;
    // Odd row, odd column closes a 2x2 window.
    assign load     = in_accept && row[0] && col[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            col          <= '0;
            row          <= '0;
            hreg         <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            last_pending <= 1'b0;
        end else begin
            if (out_accept) begin
                last_pending <= 1'b0;
            end
            // A load can only happen when the output slot is free or draining.
            if (load) begin
                out_data     <= pool_max;
                out_valid    <= 1'b1;
                last_pending <= col_last && row_last;
            end else if (out_accept) begin
                out_valid <= 1'b0;
            end
            if (in_accept) begin
                if (!col[0]) begin
                    hreg <= in_data;
                end
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
        end
    end

    // Every entry is rewritten on an even row before the odd row reads it.
    always_ff @(posedge clk) begin
        if (in_accept && !row[0] && col[0]) begin
            lb[lb_idx] <= pair_max;
        end
    end

endmodule

// File: tb/tb_maxpool2d_stream.sv
// Scoreboard bench for maxpool2d_stream: a 4x4 instance for the directed
// scenarios and a 32x32 instance for random back-to-back and throughput runs.
module tb_maxpool2d_stream;

    logic       clk = 1'b0;
    logic       rst;

    logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_frame_done;
    logic [7:0] a_in_data, a_out_data;
    logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_frame_done;
    logic [7:0] b_in_data, b_out_data;

    int         vectors = 0;
    int         miscompares = 0;

    logic [7:0] sb_a[$];
    logic [7:0] sb_b[$];
    logic [7:0] pix_a[16];
    logic [7:0] pix_b[1024];
    int         ma_idx = 0;
    int         mb_idx = 0;

    always #5 clk = ~clk;

    maxpool2d_stream #(.WIDTH(4), .HEIGHT(4), .DATA_W(8)) u_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .frame_done(a_frame_done)
    );

    maxpool2d_stream #(.WIDTH(32), .HEIGHT(32), .DATA_W(8)) u_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .frame_done(b_frame_done)
    );

    function automatic logic [7:0] max4(input logic [7:0] p, input logic [7:0] q,
                                        input logic [7:0] r, input logic [7:0] s);
        logic [7:0] m;
        m = p;
        if (q > m) m = q;
        if (r > m) m = r;
        if (s > m) m = s;
        return m;
    endfunction

    // Reference model: record the frame and push a window max when it completes.
    task automatic model_a(input logic [7:0] d);
        pix_a[ma_idx] = d;
        if (((ma_idx / 4) % 2 == 1) && ((ma_idx % 4) % 2 == 1))
            sb_a.push_back(max4(pix_a[ma_idx-5], pix_a[ma_idx-4], pix_a[ma_idx-1], d));
        ma_idx = (ma_idx + 1) % 16;
    endtask

    task automatic model_b(input logic [7:0] d);
        pix_b[mb_idx] = d;
        if (((mb_idx / 32) % 2 == 1) && ((mb_idx % 32) % 2 == 1))
            sb_b.push_back(max4(pix_b[mb_idx-33], pix_b[mb_idx-32], pix_b[mb_idx-1], d));
        mb_idx = (mb_idx + 1) % 1024;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        a_in_valid = 0; a_in_data = 0; a_out_ready = 0;
        b_in_valid = 0; b_in_data = 0; b_out_ready = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors += 8;
        if (a_out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_a_out_valid: got %b expected 0", a_out_valid); end
        if (a_out_data !== 8'd0) begin miscompares++; $display("[TB] FAIL reset_a_out_data: got %0d expected 0", a_out_data); end
        if (a_frame_done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_a_frame_done: got %b expected 0", a_frame_done); end
        if (a_in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_a_in_ready: got %b expected 1", a_in_ready); end
        if (b_out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_b_out_valid: got %b expected 0", b_out_valid); end
        if (b_out_data !== 8'd0) begin miscompares++; $display("[TB] FAIL reset_b_out_data: got %0d expected 0", b_out_data); end
        if (b_frame_done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_b_frame_done: got %b expected 0", b_frame_done); end
        if (b_in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_b_in_ready: got %b expected 1", b_in_ready); end
    endtask

    task automatic test_ramp_a;
        int         prev;
        logic       ev;
        logic [7:0] exp;
        prev = -1;
        for (int i = 0; i <= 16; i++) begin
            @(negedge clk);
            a_in_valid = (i < 16); a_in_data = 8'(i); a_out_ready = 1'b1;
            #1;
            ev = (prev == 5 || prev == 7 || prev == 13 || prev == 15);
            vectors++;
            if (a_out_valid !== ev) begin miscompares++; $display("[TB] FAIL ramp_latency cycle %0d: got %b expected %b", i, a_out_valid, ev); end
            vectors++;
            if (a_frame_done !== (prev == 15)) begin miscompares++; $display("[TB] FAIL ramp_frame_done cycle %0d: got %b expected %b", i, a_frame_done, prev == 15); end
            if (a_out_valid === 1'b1) begin
                vectors++;
                if (sb_a.size() == 0) begin miscompares++; $display("[TB] FAIL ramp_extra_output: got %0d expected none", a_out_data); end
                else begin
                    exp = sb_a.pop_front();
                    if (a_out_data !== exp) begin miscompares++; $display("[TB] FAIL ramp_data: got %0d expected %0d", a_out_data, exp); end
                end
            end
            if (i < 16) begin
                vectors++;
                if (a_in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL ramp_in_ready cycle %0d: got %b expected 1", i, a_in_ready); end
                if (a_in_ready === 1'b1) model_a(a_in_data);
            end
            prev = (i < 16) ? i : -1;
        end
        a_in_valid = 1'b0;
        vectors++;
        if (sb_a.size() != 0) begin miscompares++; $display("[TB] FAIL ramp_missing: got %0d left expected 0", sb_a.size()); sb_a.delete(); end
    endtask

    task automatic test_sweep_a;
        logic [7:0] peaks[3] = '{8'd200, 8'd255, 8'd1};
        logic [7:0] bgs[3]   = '{8'd10, 8'd10, 8'd0};
        logic [7:0] exp;
        int         p, f, j, q, got;
        p = 0; got = 0;
        for (int cyc = 0; cyc < 400 && !(p == 192 && got == 48); cyc++) begin
            @(negedge clk);
            f = p / 16; j = p % 16;
            q = ((j / 4) % 2) * 2 + (j % 2);
            a_in_valid = (p < 192);
            a_in_data  = (p < 192 && q == f % 4) ? peaks[f / 4 % 3] : bgs[f / 4 % 3];
            a_out_ready = 1'b1;
            #1;
            if (a_out_valid === 1'b1) begin
                vectors++;
                if (sb_a.size() == 0) begin miscompares++; $display("[TB] FAIL sweep_extra_output: got %0d expected none", a_out_data); end
                else begin
                    exp = sb_a.pop_front();
                    if (a_out_data !== exp) begin miscompares++; $display("[TB] FAIL sweep_data window %0d: got %0d expected %0d", got, a_out_data, exp); end
                end
                got++;
            end
            if (a_in_valid && a_in_ready) begin model_a(a_in_data); p++; end
        end
        a_in_valid = 1'b0;
        vectors++;
        if (got != 48) begin miscompares++; $display("[TB] FAIL sweep_count: got %0d expected 48", got); end
        sb_a.delete();
    endtask

    task automatic test_backpressure_a;
        logic [7:0] exp;
        int         sent, got, stall;
        sent = 0; got = 0; stall = 0;
        for (int cyc = 0; cyc < 200 && !(sent == 16 && got == 4); cyc++) begin
            @(negedge clk);
            a_in_valid  = (sent < 16); a_in_data = 8'(sent);
            a_out_ready = !(sent == 6 && stall < 5);
            #1;
            if (!a_out_ready) begin
                stall++;
                vectors += 3;
                if (a_out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_hold_valid stall %0d: got %b expected 1", stall, a_out_valid); end
                if (a_out_data !== 8'd5) begin miscompares++; $display("[TB] FAIL bp_hold_data stall %0d: got %0d expected 5", stall, a_out_data); end
                if (a_in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_in_ready stall %0d: got %b expected 0", stall, a_in_ready); end
            end
            if (a_out_valid && a_out_ready) begin
                vectors += 2;
                if (sb_a.size() == 0) begin miscompares++; $display("[TB] FAIL bp_extra_output: got %0d expected none", a_out_data); end
                else begin
                    exp = sb_a.pop_front();
                    if (a_out_data !== exp) begin miscompares++; $display("[TB] FAIL bp_data: got %0d expected %0d", a_out_data, exp); end
                end
                if (a_frame_done !== (got == 3)) begin miscompares++; $display("[TB] FAIL bp_frame_done out %0d: got %b expected %b", got, a_frame_done, got == 3); end
                got++;
            end
            if (a_in_valid && a_in_ready) begin model_a(a_in_data); sent++; end
        end
        a_in_valid = 1'b0;
        vectors++;
        if (got != 4 || sent != 16) begin miscompares++; $display("[TB] FAIL bp_timeout: got %0d outputs expected 4", got); end
        sb_a.delete();
    endtask

    task automatic test_reset_mid_a;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            a_in_valid = 1'b1; a_in_data = 8'(i); a_out_ready = 1'b1;
        end
        @(negedge clk);
        a_in_valid = 1'b0; a_out_ready = 1'b0; rst = 1'b1;
        #1;
        vectors += 2;
        if (a_out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL rstmid_pending_valid: got %b expected 1", a_out_valid); end
        if (a_out_data !== 8'd5) begin miscompares++; $display("[TB] FAIL rstmid_pending_data: got %0d expected 5", a_out_data); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors += 3;
        if (a_out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rstmid_out_valid: got %b expected 0", a_out_valid); end
        if (a_in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rstmid_in_ready: got %b expected 1", a_in_ready); end
        if (a_frame_done !== 1'b0) begin miscompares++; $display("[TB] FAIL rstmid_frame_done: got %b expected 0", a_frame_done); end
        sb_a.delete();
        ma_idx = 0;
        test_ramp_a();
    endtask

    task automatic test_back_to_back_b;
        logic [7:0] exp, cur;
        logic       oacc;
        int         sent, got, fd;
        sent = 0; got = 0; fd = 0;
        cur = 8'($urandom);
        for (int cyc = 0; cyc < 6000 && got < 512; cyc++) begin
            @(negedge clk);
            b_in_valid  = (sent < 2048); b_in_data = cur;
            b_out_ready = ($urandom_range(0, 99) < 70);
            #1;
            oacc = b_out_valid && b_out_ready;
            vectors++;
            if (b_frame_done !== (oacc && (got % 256 == 255))) begin miscompares++; $display("[TB] FAIL b2b_frame_done out %0d: got %b expected %b", got, b_frame_done, oacc && (got % 256 == 255)); end
            if (b_frame_done === 1'b1) fd++;
            if (oacc) begin
                vectors++;
                if (sb_b.size() == 0) begin miscompares++; $display("[TB] FAIL b2b_extra_output: got %0d expected none", b_out_data); end
                else begin
                    exp = sb_b.pop_front();
                    if (b_out_data !== exp) begin miscompares++; $display("[TB] FAIL b2b_data out %0d: got %0d expected %0d", got, b_out_data, exp); end
                end
                got++;
            end
            if (b_in_valid && b_in_ready) begin model_b(cur); sent++; cur = 8'($urandom); end
        end
        b_in_valid = 1'b0;
        vectors += 2;
        if (got != 512) begin miscompares++; $display("[TB] FAIL b2b_count: got %0d expected 512", got); end
        if (fd != 2) begin miscompares++; $display("[TB] FAIL b2b_frame_done_count: got %0d expected 2", fd); end
        sb_b.delete();
    endtask

    task automatic test_throughput_b;
        logic [7:0] exp;
        int         sent, got, sent_at_end;
        sent = 0; got = 0; sent_at_end = 0;
        for (int cyc = 0; cyc < 1028; cyc++) begin
            @(negedge clk);
            b_in_valid = (sent < 1024); b_in_data = 8'(sent); b_out_ready = 1'b1;
            #1;
            if (b_in_valid) begin
                vectors++;
                if (b_in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL tput_in_ready cycle %0d: got %b expected 1", cyc, b_in_ready); end
            end
            if (b_out_valid === 1'b1) begin
                vectors++;
                if (sb_b.size() == 0) begin miscompares++; $display("[TB] FAIL tput_extra_output: got %0d expected none", b_out_data); end
                else begin
                    exp = sb_b.pop_front();
                    if (b_out_data !== exp) begin miscompares++; $display("[TB] FAIL tput_data out %0d: got %0d expected %0d", got, b_out_data, exp); end
                end
                got++;
            end
            if (b_in_valid && b_in_ready) begin model_b(b_in_data); sent++; end
            if (cyc == 1023) sent_at_end = sent;
        end
        b_in_valid = 1'b0;
        vectors += 2;
        if (sent_at_end != 1024) begin miscompares++; $display("[TB] FAIL tput_accepts: got %0d in 1024 cycles expected 1024", sent_at_end); end
        if (got != 256) begin miscompares++; $display("[TB] FAIL tput_count: got %0d expected 256", got); end
    endtask

    initial begin
        test_reset();
        test_ramp_a();
        test_sweep_a();
        test_backpressure_a();
        test_reset_mid_a();
        test_back_to_back_b();
        test_throughput_b();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
